// File: rtl/ysyx_22050243_lsu.sv
// ysyx_22050243_lsu -- load/store unit between EX and the data-memory bus.
// Takes one request at a time, issues a valid/ready bus request with an
// aligned address and byte mask, and returns an extended load result.
// Optional feature macro: YSYX_22050243_LSU_MISALIGN_EN
//   defined   : misaligned h/w/d accesses report rsp_err and skip the bus
//   undefined : low address bits below the access size are dropped
module ysyx_22050243_lsu #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_r,
  input  logic              mem_w,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [7:0]        bus_wmask,
  input  logic              bus_rsp_valid,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic                mem_r_q, mem_r_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [2:0]          off_q, off_d;
  logic                bus_req_valid_q, bus_req_valid_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [7:0]          bus_wmask_q, bus_wmask_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  // Address bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] low_bits(input logic [1:0] size);
    case (size)
      2'd0:    low_bits = 3'b000;
      2'd1:    low_bits = 3'b001;
      2'd2:    low_bits = 3'b011;
      default: low_bits = 3'b111;
    endcase
  endfunction

  // Byte enables for the access size before shifting into its lane.
  function automatic logic [7:0] base_mask(input logic [1:0] size);
    case (size)
      2'd0:    base_mask = 8'h01;
      2'd1:    base_mask = 8'h03;
      2'd2:    base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
  endfunction

  logic [2:0]        in_off;
  logic              in_misalign;
  logic              in_err;
  logic [DATA_W-1:0] ld_shift;
  logic [DATA_W-1:0] ld_ext;
  logic              ld_sx;

  // Decode the incoming request: lane offset, error and misalignment.
  always_comb begin
    in_misalign = (addr[2:0] & low_bits(funct3[1:0])) != 3'b000;
    // Dropping the sub-size bits turns a misaligned access into the
    // enclosing aligned one; for aligned accesses it is a no-op.
    in_off = addr[2:0] & ~low_bits(funct3[1:0]);
    in_err = (funct3 == 3'b111) || (mem_w && funct3[2]) || (mem_r && mem_w);
`ifdef YSYX_22050243_LSU_MISALIGN_EN
    if ((mem_r || mem_w) && in_misalign) in_err = 1'b1;
`endif
  end

  // Lane-extract the returned doubleword and sign/zero extend to 64 bits.
  always_comb begin
    ld_shift = bus_rdata >> {off_q, 3'b000};
    ld_sx    = ~funct3_q[2];
    case (funct3_q[1:0])
      2'd0:    ld_ext = {{56{ld_sx & ld_shift[7]}},  ld_shift[7:0]};
      2'd1:    ld_ext = {{48{ld_sx & ld_shift[15]}}, ld_shift[15:0]};
      2'd2:    ld_ext = {{32{ld_sx & ld_shift[31]}}, ld_shift[31:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  // Next-state and next-output logic of the request FSM.
  always_comb begin
    state_d         = state_q;
    mem_r_d         = mem_r_q;
    funct3_d        = funct3_q;
    off_d           = off_q;
    bus_req_valid_d = bus_req_valid_q;
    bus_we_d        = bus_we_q;
    bus_addr_d      = bus_addr_q;
    bus_wdata_d     = bus_wdata_q;
    bus_wmask_d     = bus_wmask_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_rdata_d     = rsp_rdata_q;
    rsp_err_d       = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          mem_r_d  = mem_r;
          funct3_d = funct3;
          off_d    = in_off;
          if (in_err) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (!mem_r && !mem_w) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
          end else begin
            state_d         = REQ;
            bus_req_valid_d = 1'b1;
            bus_we_d        = mem_w;
            bus_addr_d      = {addr[ADDR_W-1:3], 3'b000};
            bus_wdata_d     = wdata << {in_off, 3'b000};
            bus_wmask_d     = base_mask(funct3[1:0]) << in_off;
          end
        end
      end
      REQ: begin
        if (bus_req_ready) begin
          state_d         = WAIT;
          bus_req_valid_d = 1'b0;
          bus_we_d        = 1'b0;
          bus_addr_d      = '0;
          bus_wdata_d     = '0;
          bus_wmask_d     = '0;
        end
      end
      WAIT: begin
        if (bus_rsp_valid) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = mem_r_q ? ld_ext : '0;
        end
      end
      default: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end
    endcase
  end

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      mem_r_q         <= 1'b0;
      funct3_q        <= 3'b000;
      off_q           <= 3'b000;
      bus_req_valid_q <= 1'b0;
      bus_we_q        <= 1'b0;
      bus_addr_q      <= '0;
      bus_wdata_q     <= '0;
      bus_wmask_q     <= 8'h00;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= '0;
      rsp_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      mem_r_q         <= mem_r_d;
      funct3_q        <= funct3_d;
      off_q           <= off_d;
      bus_req_valid_q <= bus_req_valid_d;
      bus_we_q        <= bus_we_d;
      bus_addr_q      <= bus_addr_d;
      bus_wdata_q     <= bus_wdata_d;
      bus_wmask_q     <= bus_wmask_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      rsp_err_q       <= rsp_err_d;
    end
  end

  // req_ready is gated by reset so every output reads 0 while rst_n is low.
  assign req_ready     = (state_q == IDLE) && rst_n;
  assign bus_req_valid = bus_req_valid_q;
  assign bus_we        = bus_we_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wdata     = bus_wdata_q;
  assign bus_wmask     = bus_wmask_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_ysyx_22050243_lsu.sv
// tb_ysyx_22050243_lsu -- randomized bench with a byte-level memory model.
// Honours YSYX_22050243_LSU_MISALIGN_EN the same way as the design.
module tb_ysyx_22050243_lsu;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        mem_r = 1'b0;
  logic        mem_w = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic        bus_req_valid;
  logic        bus_req_ready = 1'b0;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wmask;
  logic        bus_rsp_valid = 1'b0;
  logic [63:0] bus_rdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  ysyx_22050243_lsu #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .mem_r(mem_r), .mem_w(mem_w), .funct3(funct3), .addr(addr), .wdata(wdata),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int txn_no = 0;

  // ref_mem follows the architectural effect of each request; bus_mem is
  // what the bus actually sees, updated only through the DUT's writes.
  logic [7:0] ref_mem [128];
  logic [7:0] bus_mem [128];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input logic r, input logic w, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd,
                        input int qd, input int rd, input int wbd,
                        output logic [63:0] got);
    int          n, idx, aidx, off;
    logic        err, noop;
    logic [63:0] ea, exp_rd, exp_wd, lanes, cap_wd;
    logic [7:0]  exp_mask, cap_mask;
    n    = 1 << f3[1:0];
    err  = (f3 == 3'd7) || (w && f3[2]) || (r && w);
`ifdef YSYX_22050243_LSU_MISALIGN_EN
    if ((r || w) && (a % 64'(n)) != 0) err = 1'b1;
`endif
    noop = !err && !r && !w;
    ea   = a - (a % 64'(n));
    idx  = int'(ea - BASE);
    aidx = idx - (idx % 8);
    off  = idx % 8;
    exp_rd = '0; exp_wd = '0; lanes = '0; exp_mask = '0;
    for (int i = 0; i < n; i++) begin
      exp_mask[off + i]        = 1'b1;
      lanes[8*(off+i) +: 8]    = 8'hFF;
      exp_wd[8*(off+i) +: 8]   = wd[8*i +: 8];
      if (r && !err) exp_rd[8*i +: 8] = ref_mem[idx + i];
    end
    if (r && !err && !f3[2] && n < 8 && exp_rd[8*n-1])
      for (int i = n; i < 8; i++) exp_rd[8*i +: 8] = 8'hFF;

    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; mem_r = r; mem_w = w; funct3 = f3; addr = a; wdata = wd;
    tick();
    req_valid = 1'b0; mem_r = 1'b0; mem_w = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;

    if (err || noop) begin
      check("bus_valid_skip", 64'(bus_req_valid), 64'd0);
    end else begin
      cap_wd = '0; cap_mask = '0;
      for (int c = 0; c <= qd; c++) begin
        check("bus_req_valid", 64'(bus_req_valid), 64'd1);
        check("bus_addr", bus_addr, BASE + 64'(aidx));
        check("bus_we", 64'(bus_we), 64'(w));
        if (w) begin
          check("bus_wmask", 64'(bus_wmask), 64'(exp_mask));
          check("bus_wdata", bus_wdata & lanes, exp_wd);
        end
        check("req_ready_req", 64'(req_ready), 64'd0);
        cap_wd = bus_wdata; cap_mask = bus_wmask;
        if (c == qd) bus_req_ready = 1'b1;
        tick();
        bus_req_ready = 1'b0;
      end
      if (w) begin
        for (int k = 0; k < 8; k++)
          if (cap_mask[k]) bus_mem[aidx + k] = cap_wd[8*k +: 8];
        for (int i = 0; i < n; i++) ref_mem[idx + i] = wd[8*i +: 8];
      end
      for (int c = 0; c <= rd; c++) begin
        check("wait_rsp_valid", 64'(rsp_valid), 64'd0);
        check("wait_bus_valid", 64'(bus_req_valid), 64'd0);
        bus_rdata = {$urandom, $urandom};
        if (c == rd) begin
          bus_rsp_valid = 1'b1;
          if (r) for (int k = 0; k < 8; k++) bus_rdata[8*k +: 8] = bus_mem[aidx + k];
        end
        tick();
        bus_rsp_valid = 1'b0;
      end
    end

    got = rsp_rdata;
    for (int c = 0; c <= wbd; c++) begin
      check("rsp_valid", 64'(rsp_valid), 64'd1);
      check("rsp_rdata", rsp_rdata, exp_rd);
      check("rsp_err", 64'(rsp_err), 64'(err));
      check("req_ready_done", 64'(req_ready), 64'd0);
      if (c == wbd) rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
    check("rsp_valid_clear", 64'(rsp_valid), 64'd0);
    check("req_ready_back", 64'(req_ready), 64'd1);
    $display("txn %0d r=%0d w=%0d f3=%0d addr=%h wdata=%h rdata=%h err=%0d",
             txn_no, r, w, f3, a, wd, got, err);
    txn_no++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_bus_req_valid"}, 64'(bus_req_valid), 64'd0);
    check({tag, "_bus_we"}, 64'(bus_we), 64'd0);
    check({tag, "_bus_addr"}, bus_addr, 64'd0);
    check({tag, "_bus_wdata"}, bus_wdata, 64'd0);
    check({tag, "_bus_wmask"}, 64'(bus_wmask), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 64'd0);
    check({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
  endtask

  initial begin
    logic [63:0] got, dw;
    int          sel, n;
    logic [63:0] a;
    logic [2:0]  f3;

    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = 8'($urandom);
      bus_mem[i] = ref_mem[i];
    end
    dw = 64'h1122_3344_8566_7788;
    for (int k = 0; k < 8; k++) begin
      ref_mem[k] = dw[8*k +: 8];
      bus_mem[k] = dw[8*k +: 8];
    end

    // Power-on reset
    #2;
    check_all_zero("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("req_ready_after_reset", 64'(req_ready), 64'd1);

    // Byte loads, signed and unsigned
    do_txn(1'b1, 1'b0, 3'b000, BASE + 64'd3, 64'd0, 0, 0, 0, got);
    check("lb_value", got, 64'hFFFF_FFFF_FFFF_FF85);
    do_txn(1'b1, 1'b0, 3'b100, BASE + 64'd3, 64'd0, 0, 0, 0, got);
    check("lbu_value", got, 64'h85);

    // Store halfword into the top lane, then stalls on both handshakes
    do_txn(1'b0, 1'b1, 3'b001, BASE + 64'd6, 64'hABCD, 0, 0, 0, got);
    check("sh_rdata", got, 64'd0);
    do_txn(1'b1, 1'b0, 3'b001, BASE + 64'd6, 64'd0, 5, 2, 3, got);
    check("lh_after_sh", got, 64'hFFFF_FFFF_FFFF_ABCD);

    // Illegal funct3 on a load and on a store
    do_txn(1'b1, 1'b0, 3'b111, BASE + 64'd8, 64'd0, 0, 0, 0, got);
    do_txn(1'b0, 1'b1, 3'b111, BASE + 64'd8, 64'h1234, 0, 0, 0, got);

    // Misaligned word load
    do_txn(1'b1, 1'b0, 3'b010, BASE + 64'd2, 64'd0, 0, 0, 0, got);
`ifdef YSYX_22050243_LSU_MISALIGN_EN
    check("lw_misaligned", got, 64'd0);
`else
    check("lw_misaligned", got, 64'hFFFF_FFFF_8566_7788);
`endif

    // Reset while waiting for the response, then a late response pulse
    req_valid = 1'b1; mem_r = 1'b1; funct3 = 3'b011; addr = BASE + 64'd16;
    tick();
    req_valid = 1'b0; mem_r = 1'b0; funct3 = 3'b000; addr = '0;
    bus_req_ready = 1'b1;
    tick();
    bus_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    tick();
    rst_n = 1'b1;
    bus_rsp_valid = 1'b1; bus_rdata = 64'hDEAD_BEEF_0000_0001;
    tick();
    bus_rsp_valid = 1'b0;
    check("late_rsp_valid", 64'(rsp_valid), 64'd0);
    check("late_req_ready", 64'(req_ready), 64'd1);
    tick();
    check("late_rsp_valid2", 64'(rsp_valid), 64'd0);
    do_txn(1'b1, 1'b0, 3'b011, BASE + 64'd16, 64'd0, 1, 1, 1, got);

    // Random traffic
    for (int t = 0; t < 200; t++) begin
      sel = $urandom_range(0, 11);
      f3  = 3'($urandom_range(0, 7));
      n   = 1 << f3[1:0];
      a   = BASE + 64'($urandom_range(0, 127));
      if ($urandom_range(0, 2) != 0) a = a - (a % 64'(n));
      do_txn(sel == 1 || (sel >= 2 && sel <= 6), sel == 1 || sel >= 7, f3, a,
             {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 2), got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
